// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: round-robin arbiter of NREQ requestors onto NPORT memory ports.
// Each port runs an IDLE/BUSY FSM; a requestor holds at most one transaction.

package mem_arbiter_n_pkg;
    localparam int WORD_SIZE  = 16;
    localparam int QWORD_SIZE = 64;
endpackage

module mem_arbiter_n
    import mem_arbiter_n_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int NPORT = 2,
    parameter logic [NPORT-1:0] WRITE_MASK = 2'b10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_write,
    input  logic [NREQ-1:0]             req_qword,
    input  logic [NREQ*WORD_SIZE-1:0]   req_addr,
    input  logic [NREQ*QWORD_SIZE-1:0]  req_wdata,
    output logic [NREQ-1:0]             req_accept,
    output logic [NREQ-1:0]             req_done,
    output logic [NREQ*QWORD_SIZE-1:0]  req_rdata,
    input  logic [NPORT-1:0]            mem_ready,
    input  logic [NPORT-1:0]            mem_ack,
    input  logic [NPORT*QWORD_SIZE-1:0] mem_rdata,
    output logic [NPORT-1:0]            mem_read,
    output logic [NPORT-1:0]            mem_write,
    output logic [NPORT-1:0]            mem_write_q,
    output logic [NPORT*WORD_SIZE-1:0]  mem_addr,
    output logic [NPORT*QWORD_SIZE-1:0] mem_wdata
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q [NPORT];
    state_t          state_d [NPORT];
    logic [OW-1:0]   owner_q [NPORT];
    logic [OW-1:0]   grant_req [NPORT];
    logic [NPORT-1:0] grant_vld;
    logic [NREQ-1:0] busy_req;
    logic [OW-1:0]   rr_q;
    logic [OW-1:0]   rr_d;
    logic            scan_found;
    int              scan_idx;
    logic [OW-1:0]   scan_sel;

    // A requestor is outstanding while any BUSY port names it as owner.
    always_comb begin
        busy_req = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (state_q[p] == BUSY && owner_q[p] == OW'(r)) begin
                    busy_req[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_vld  = '0;
        req_accept = '0;
        rr_d       = rr_q;
        scan_found = 1'b0;
        scan_idx   = 0;
        scan_sel   = '0;
        for (int p = 0; p < NPORT; p++) begin
            grant_req[p] = '0;
        end
        for (int p = 0; p < NPORT; p++) begin
            scan_found = 1'b0;
            if (!reset && state_q[p] == IDLE && mem_ready[p]) begin
                for (int k = 0; k < NREQ; k++) begin
                    scan_idx = int'(rr_q) + k;
                    if (scan_idx >= NREQ) begin
                        scan_idx = scan_idx - NREQ;
                    end
                    scan_sel = OW'(scan_idx);
                    if (!scan_found && req_valid[scan_sel]
                        && !busy_req[scan_sel] && !req_accept[scan_sel]
                        && (!req_write[scan_sel] || WRITE_MASK[p])) begin
                        scan_found          = 1'b1;
                        grant_vld[p]        = 1'b1;
                        grant_req[p]        = scan_sel;
                        req_accept[scan_sel] = 1'b1;
                        rr_d = (scan_idx + 1 >= NREQ) ? '0 : OW'(scan_idx + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            state_d[p] = state_q[p];
            unique case (state_q[p])
                IDLE: if (grant_vld[p]) state_d[p] = BUSY;
                BUSY: if (mem_ack[p]) state_d[p] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPORT; p++) begin
                state_q[p] <= IDLE;
                owner_q[p] <= '0;
            end
            rr_q        <= '0;
            mem_read    <= '0;
            mem_write   <= '0;
            mem_write_q <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            req_done    <= '0;
            req_rdata   <= '0;
        end else begin
            rr_q     <= rr_d;
            req_done <= '0;
            for (int p = 0; p < NPORT; p++) begin
                state_q[p] <= state_d[p];
                if (grant_vld[p]) begin
                    owner_q[p] <= grant_req[p];
                    mem_addr[p*WORD_SIZE +: WORD_SIZE] <=
                        req_addr[grant_req[p]*WORD_SIZE +: WORD_SIZE];
                    mem_wdata[p*QWORD_SIZE +: QWORD_SIZE] <=
                        req_wdata[grant_req[p]*QWORD_SIZE +: QWORD_SIZE];
                    mem_read[p]    <= !req_write[grant_req[p]];
                    mem_write[p]   <= req_write[grant_req[p]]
                                      && !req_qword[grant_req[p]];
                    mem_write_q[p] <= req_write[grant_req[p]]
                                      && req_qword[grant_req[p]];
                end else if (state_q[p] == BUSY && mem_ack[p]) begin
                    mem_read[p]          <= 1'b0;
                    mem_write[p]         <= 1'b0;
                    mem_write_q[p]       <= 1'b0;
                    req_done[owner_q[p]] <= 1'b1;
                    // Only reads update the owner's read-data register.
                    if (mem_read[p]) begin
                        req_rdata[owner_q[p]*QWORD_SIZE +: QWORD_SIZE] <=
                            mem_rdata[p*QWORD_SIZE +: QWORD_SIZE];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed bench for mem_arbiter_n with a done/rdata scoreboard.
// Inputs change 1ns after posedge; checks run 2ns after posedge and at negedge.

module tb_mem_arbiter_n;
    import mem_arbiter_n_pkg::*;

    localparam int NREQ  = 2;
    localparam int NPORT = 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_write;
    logic [NREQ-1:0]             req_qword;
    logic [NREQ*WORD_SIZE-1:0]   req_addr;
    logic [NREQ*QWORD_SIZE-1:0]  req_wdata;
    logic [NREQ-1:0]             req_accept;
    logic [NREQ-1:0]             req_done;
    logic [NREQ*QWORD_SIZE-1:0]  req_rdata;
    logic [NPORT-1:0]            mem_ready;
    logic [NPORT-1:0]            mem_ack;
    logic [NPORT*QWORD_SIZE-1:0] mem_rdata;
    logic [NPORT-1:0]            mem_read;
    logic [NPORT-1:0]            mem_write;
    logic [NPORT-1:0]            mem_write_q;
    logic [NPORT*WORD_SIZE-1:0]  mem_addr;
    logic [NPORT*QWORD_SIZE-1:0] mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter_n #(
        .NREQ(NREQ),
        .NPORT(NPORT),
        .WRITE_MASK(2'b10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_qword(req_qword),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_accept(req_accept),
        .req_done(req_done),
        .req_rdata(req_rdata),
        .mem_ready(mem_ready),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_write_q(mem_write_q),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata)
    );

    typedef struct {
        int          r;
        logic [63:0] d;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [63:0] last_rd [NREQ];
    logic [63:0] dg;
    logic [1:0]  exp_acc;
    int          order [4];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic w,
                           input logic q, input logic [15:0] a,
                           input logic [63:0] d);
        req_valid[r] = v;
        req_write[r] = w;
        req_qword[r] = q;
        req_addr[r*WORD_SIZE +: WORD_SIZE] = a;
        req_wdata[r*QWORD_SIZE +: QWORD_SIZE] = d;
    endtask

    task automatic ack(input int p, input logic [63:0] d);
        mem_ack[p] = 1'b1;
        mem_rdata[p*QWORD_SIZE +: QWORD_SIZE] = d;
    endtask

    task automatic expect_done(input int r, input logic [63:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        sbq.push_back(e);
    endtask

    // Scoreboard: every done pulse pops the oldest expected completion.
    always @(negedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREQ; r++) begin
                if (req_done[r]) begin
                    if (sbq.size() == 0) begin
                        chk("done_unexpected", {63'd0, req_done[r]}, 64'd0);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("done_owner", 64'(r), 64'(mon_e.r));
                        chk("done_rdata", req_rdata[r*QWORD_SIZE +: QWORD_SIZE],
                            mon_e.d);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_qword = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = '0;
        mem_ack   = '0;
        mem_rdata = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        order[0] = 0;
        order[1] = 1;
        order[2] = 0;
        order[3] = 1;

        // reset state, accept held low under reset
        tick();
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, 64'd0);
        mem_ready = 2'b11;
        settle();
        chk("rst_accept", 64'(req_accept), 64'd0);
        chk("rst_strobes", 64'({mem_read, mem_write, mem_write_q}), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_rdata0", req_rdata[63:0], 64'd0);
        chk("rst_rdata1", req_rdata[127:64], 64'd0);
        req_valid = '0;
        mem_ready = '0;
        tick();
        reset = 1'b0;

        // single read through port0
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, 64'd0);
        mem_ready = 2'b01;
        settle();
        chk("t1_accept", 64'(req_accept), 64'd1);
        tick();
        req_valid = '0;
        mem_ready = '0;
        settle();
        chk("t1_read", 64'(mem_read), 64'd1);
        chk("t1_addr", 64'(mem_addr[15:0]), 64'h0040);
        chk("t1_wr_strobes", 64'({mem_write, mem_write_q}), 64'd0);
        tick();
        tick();
        ack(0, 64'h1122334455667788);
        expect_done(0, 64'h1122334455667788);
        settle();
        chk("t1_read_ackcyc", 64'(mem_read), 64'd1);
        tick();
        mem_ack = '0;
        settle();
        chk("t1_done", 64'(req_done), 64'd1);
        chk("t1_read_clr", 64'(mem_read), 64'd0);
        chk("t1_rdata", req_rdata[63:0], 64'h1122334455667788);
        tick();
        settle();
        chk("t1_done_pulse", 64'(req_done), 64'd0);
        chk("t1_rdata_hold", req_rdata[63:0], 64'h1122334455667788);

        // rr back to 0, two simultaneous reads
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0200, 64'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0300, 64'd0);
        mem_ready = 2'b11;
        settle();
        chk("t2_accept", 64'(req_accept), 64'd3);
        tick();
        req_valid = '0;
        mem_ready = '0;
        settle();
        chk("t2_read", 64'(mem_read), 64'd3);
        chk("t2_addr0", 64'(mem_addr[15:0]), 64'h0200);
        chk("t2_addr1", 64'(mem_addr[31:16]), 64'h0300);
        tick();
        ack(0, 64'hA0A0A0A0A0A0A0A0);
        ack(1, 64'hB1B1B1B1B1B1B1B1);
        expect_done(0, 64'hA0A0A0A0A0A0A0A0);
        expect_done(1, 64'hB1B1B1B1B1B1B1B1);
        last_rd[0] = 64'hA0A0A0A0A0A0A0A0;
        last_rd[1] = 64'hB1B1B1B1B1B1B1B1;
        tick();
        mem_ack = '0;
        settle();
        chk("t2_done", 64'(req_done), 64'd3);
        chk("t2_read_clr", 64'(mem_read), 64'd0);

        // continuous reads, one port: alternating grant order
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0400, 64'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0500, 64'd0);
        mem_ready = 2'b01;
        settle();
        for (int g = 0; g < 4; g++) begin
            exp_acc = 2'b01 << order[g];
            dg = 64'hC000000000000000 | 64'(g);
            chk($sformatf("rr_accept%0d", g), 64'(req_accept), 64'(exp_acc));
            tick();
            settle();
            chk($sformatf("rr_read%0d", g), 64'(mem_read), 64'd1);
            chk($sformatf("rr_addr%0d", g), 64'(mem_addr[15:0]),
                (order[g] == 1) ? 64'h0500 : 64'h0400);
            tick();
            tick();
            ack(0, dg);
            expect_done(order[g], dg);
            last_rd[order[g]] = dg;
            if (g == 3) req_valid = '0;
            settle();
            chk($sformatf("rr_noregrant%0d", g), 64'(req_accept), 64'd0);
            tick();
            mem_ack = '0;
            settle();
            chk($sformatf("rr_done%0d", g), 64'(req_done), 64'(exp_acc));
        end

        // qword write waits for the only write-capable port
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0600, 64'd0);
        mem_ready = 2'b10;
        settle();
        chk("t3_acc_r0", 64'(req_accept), 64'd1);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b1, 1'b1, 16'h0100, 64'hDEADBEEFCAFEF00D);
        mem_ready = 2'b01;
        settle();
        chk("t3_wait0", 64'(req_accept), 64'd0);
        chk("t3_p1_read", 64'(mem_read), 64'd2);
        tick();
        settle();
        chk("t3_wait1", 64'(req_accept), 64'd0);
        tick();
        ack(1, 64'h5555666677778888);
        expect_done(0, 64'h5555666677778888);
        last_rd[0] = 64'h5555666677778888;
        mem_ready = 2'b11;
        settle();
        chk("t3_ack_cycle", 64'(req_accept), 64'd0);
        tick();
        mem_ack = '0;
        settle();
        chk("t3_accept", 64'(req_accept), 64'd2);
        chk("t3_done0", 64'(req_done), 64'd1);
        tick();
        req_valid = '0;
        mem_ready = '0;
        settle();
        chk("t3_wq", 64'(mem_write_q), 64'd2);
        chk("t3_rw", 64'({mem_read, mem_write}), 64'd0);
        chk("t3_addr1", 64'(mem_addr[31:16]), 64'h0100);
        chk("t3_wdata1", mem_wdata[127:64], 64'hDEADBEEFCAFEF00D);
        tick();
        ack(1, 64'h0BAD0BAD0BAD0BAD);
        expect_done(1, last_rd[1]);
        tick();
        mem_ack = '0;
        settle();
        chk("t3_wdone", 64'(req_done), 64'd2);
        chk("t3_wq_clr", 64'(mem_write_q), 64'd0);
        chk("t3_rdata1_keep", req_rdata[127:64], last_rd[1]);

        // word write
        set_req(0, 1'b1, 1'b1, 1'b0, 16'h0700, 64'h0000000000001234);
        mem_ready = 2'b11;
        settle();
        chk("t5_accept", 64'(req_accept), 64'd1);
        tick();
        req_valid = '0;
        mem_ready = '0;
        settle();
        chk("t5_w", 64'(mem_write), 64'd2);
        chk("t5_wq_r", 64'({mem_write_q, mem_read}), 64'd0);
        chk("t5_wdata", mem_wdata[127:64], 64'h0000000000001234);
        tick();
        ack(1, 64'hFEEDFEEDFEEDFEED);
        expect_done(0, last_rd[0]);
        tick();
        mem_ack = '0;
        settle();
        chk("t5_done", 64'(req_done), 64'd1);

        // reset abandons an in-flight read
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0800, 64'd0);
        mem_ready = 2'b01;
        settle();
        chk("t4_accept", 64'(req_accept), 64'd1);
        tick();
        req_valid = '0;
        mem_ready = '0;
        settle();
        chk("t4_read", 64'(mem_read), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack(0, 64'hFFFFFFFFFFFFFFFF);
        settle();
        chk("t4_read_clr", 64'(mem_read), 64'd0);
        chk("t4_rdata0", req_rdata[63:0], 64'd0);
        tick();
        mem_ack = '0;
        settle();
        chk("t4_no_done", 64'(req_done), 64'd0);
        chk("t4_still_idle", 64'(mem_read), 64'd0);
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0900, 64'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0A00, 64'd0);
        mem_ready = 2'b01;
        settle();
        chk("t4_rr0", 64'(req_accept), 64'd1);
        tick();
        req_valid = '0;
        mem_ready = '0;
        settle();
        chk("t4_addr", 64'(mem_addr[15:0]), 64'h0900);
        tick();
        ack(0, 64'h0123456789ABCDEF);
        expect_done(0, 64'h0123456789ABCDEF);
        tick();
        mem_ack = '0;
        settle();
        chk("t4_done", 64'(req_done), 64'd1);

        tick();
        tick();
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
